sram_access_arbiter: RTL and testbench
======================================

Name: sram_access_arbiter

Overview:
- Shares the single-port result/operand SRAM among three requesters: the X-byte input loader, the ALU sequencer, and the host readback port.
- The grant decision is combinational. The SRAM command is registered. Read data returns tagged with its owner.
- Sits between the controller-sequenced datapath and the SRAM macro. It replaces ad-hoc cs_n/web muxing with a round-robin arbiter that has a bounded burst.

Parameters:
- ADDR_W, 8, SRAM word address width.
- DATA_W, 32, SRAM data width.
- MAX_HOLD, 4, maximum consecutive grants to one owner while another requester is pending (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- alu_req  in  1  ALU access request.
- alu_we  in  1  ALU write (1) or read (0).
- alu_addr  in  ADDR_W  ALU address.
- alu_wdata  in  DATA_W  ALU write data.
- alu_gnt  out  1  ALU grant, combinational.
- ld_req  in  1  loader write request (loader writes only).
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt  out  1  loader grant, combinational.
- rd_req  in  1  host readback request (reads only).
- rd_addr  in  ADDR_W  readback address.
- rd_gnt  out  1  readback grant, combinational.
- mem_cs_n  out  1  SRAM chip select, active-low, registered.
- mem_web  out  1  SRAM write enable, active-low, registered.
- mem_addr  out  ADDR_W  SRAM address, registered.
- mem_wdata  out  DATA_W  SRAM write data, registered.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read command.
- rdata  out  DATA_W  registered copy of mem_rdata.
- rdata_valid  out  1  one-cycle pulse marking rdata valid.
- rdata_owner  out  2  owner tag for rdata.
- busy  out  1  high when a command is issued this cycle or a read is in flight.

Behaviour:
- Reset (rst=0, async):
  - mem_cs_n=1, mem_web=1, mem_addr=0, mem_wdata=0.
  - rdata=0, rdata_valid=0, rdata_owner=OWN_NONE, busy=0.
  - Round-robin pointer set to ALU, hold counter=0, owner=OWN_NONE.
  - In-flight reads are discarded with no valid pulse.
- Handshake:
  - A requester holds req, addr and data stable until it samples gnt=1.
  - On that same clock edge the transfer is accepted. The requester may then drop req or present its next access.
  - A request is never withdrawn before grant.
- Grant: at most one gnt high per cycle, computed combinationally from the req inputs, the owner register and the hold counter.
- Command timing:
  - Grant in cycle t → mem_cs_n=0 with the granted addr/data/web in cycle t+1.
  - mem_web=0 only for alu_we=1 or a loader grant.
  - For reads, mem_rdata is valid in t+2. rdata and rdata_valid are registered and appear in cycle t+3, with rdata_owner equal to the owner granted in t.
- No grant in cycle t → mem_cs_n=1 and mem_web=1 in t+1. mem_addr and mem_wdata hold their previous values.
- Arbitration:
  - Owner keeps the grant while its req stays high, up to MAX_HOLD consecutive grants.
  - If the counter reaches MAX_HOLD and another req is pending, the grant rotates to the next requester in round-robin order ALU→LD→RD→ALU, starting after the current owner. The counter resets to 1.
  - If the counter reaches MAX_HOLD and no other req is pending, the owner continues and the counter restarts at 1.
  - If the owner drops req, the next pending requester in round-robin order is granted in the same cycle.
- Idle: no req → owner=OWN_NONE, the round-robin pointer is kept, and no gnt is asserted.
- Simultaneous requests from idle: the round-robin pointer decides. The pointer advances past each granted owner.
- Back-to-back:
  - Full throughput of one command per cycle.
  - A read followed by a write to the same address is allowed because it is ordered by the single port.
  - Reads pipeline: up to 2 reads can be in flight, each tagged independently.
- busy = !mem_cs_n OR a read-in-flight flag.

Decomposition:
- Package sram_arb_pkg:
  - Owner encoding OWN_ALU=2'd0, OWN_LD=2'd1, OWN_RD=2'd2, OWN_NONE=2'd3.
  - Function next_rr(owner).
  - Default localparams for ADDR_W and DATA_W.
- One sub-module, rr_pick3: a combinational 3-way round-robin picker. Inputs: req vector, pointer. Outputs: one-hot grant and encoded owner.
- The hold counter, command registers and read-tag pipeline live in the top.

Test Plan:
- Reset mid-read: ALU read granted, rst pulled low in t+1 → no rdata_valid; all outputs at reset values; pointer=ALU after release.
- Single loader write: ld_req with addr 0x10, data 0xDEADBEEF → ld_gnt same cycle; next cycle mem_cs_n=0, mem_web=0, addr 0x10, data 0xDEADBEEF.
- Readback latency: rd_req addr 0x05 granted at t, SRAM returns 0x12345678 at t+2 → rdata=0x12345678, rdata_valid=1, rdata_owner=2 at t+3, for one cycle only.
- Burst bound: ALU holds req for 10 cycles with rd_req pending from cycle 0 (MAX_HOLD=4) → exactly 4 ALU grants, then 1 RD grant, then ALU resumes.
- Three-way contention from idle with pointer=ALU: all requesters issue 1 access each → grant order ALU, LD, RD on consecutive cycles; never two gnt high in one cycle.
- Lone owner past limit: only ld_req for 9 cycles → 9 consecutive ld_gnt cycles with no gap; mem_cs_n low for cycles 2..10.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the SRAM access arbiter:
//   - owner_e      : requester / read-tag encoding (ALU, loader, readback, none)
//   - next_rr()    : round-robin successor, ALU -> LD -> RD -> ALU
//   - owner_onehot(): owner to {rd, ld, alu} one-hot request-vector position
//   - default widths for the address and data paths
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_HOLD = 4;
  // Hold counter is wide enough for MAX_HOLD up to 15.
  localparam int HOLD_CNT_W   = 4;

  typedef enum logic [1:0] {
    OWN_ALU  = 2'd0,
    OWN_LD   = 2'd1,
    OWN_RD   = 2'd2,
    OWN_NONE = 2'd3
  } owner_e;

  // OWN_NONE maps to ALU so an idle pointer always restarts the ring cleanly.
  function automatic owner_e next_rr(input owner_e owner);
    case (owner)
      OWN_ALU: next_rr = OWN_LD;
      OWN_LD:  next_rr = OWN_RD;
      default: next_rr = OWN_ALU;
    endcase
  endfunction

  // Bit order matches the request vector {rd, ld, alu}.
  function automatic logic [2:0] owner_onehot(input owner_e owner);
    case (owner)
      OWN_ALU: owner_onehot = 3'b001;
      OWN_LD:  owner_onehot = 3'b010;
      OWN_RD:  owner_onehot = 3'b100;
      default: owner_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sram_access_arbiter_rr_pick3.sv
// ---------------------------------------------------------------------------
// rr_pick3
// Combinational 3-way round-robin picker. Searches the request vector
// starting at the pointer position and wrapping ALU -> LD -> RD -> ALU;
// the first pending requester wins.
// Ports:
//   req   in  3  request vector {rd, ld, alu}
//   ptr   in  2  first position to search (OWN_NONE treated as ALU)
//   gnt   out 3  one-hot grant, zero when no request is pending
//   owner out 2  encoded winner, OWN_NONE when no request is pending
// ---------------------------------------------------------------------------
module rr_pick3
  import sram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  owner_e     ptr,
  output logic [2:0] gnt,
  output owner_e     owner
);

  owner_e cand;

  always_comb begin
    gnt   = 3'b000;
    owner = OWN_NONE;
    cand  = (ptr == OWN_NONE) ? OWN_ALU : ptr;
    for (int i = 0; i < 3; i++) begin
      if ((owner == OWN_NONE) && ((req & owner_onehot(cand)) != 3'b000)) begin
        gnt   = owner_onehot(cand);
        owner = cand;
      end
      cand = next_rr(cand);
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter
// Shares one single-port SRAM among the ALU sequencer (read/write), the
// X-byte input loader (write only) and the host readback port (read only).
// Grants are combinational; the SRAM command is registered one cycle after
// the grant; read data comes back registered three cycles after the grant,
// tagged with the owner that issued the read.
//
// Arbitration: the current owner keeps the port while it keeps requesting,
// for at most MAX_HOLD consecutive grants when someone else is waiting; the
// round-robin pointer always sits just past the last granted owner, so both
// rotation and idle restarts search from there.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-low reset
//   alu_req/we/addr/wdata, alu_gnt  ALU access and its grant
//   ld_req/addr/wdata, ld_gnt       loader write and its grant
//   rd_req/addr, rd_gnt             host readback and its grant
//   mem_cs_n/web/addr/wdata         registered SRAM command
//   mem_rdata                       SRAM read data (one cycle after command)
//   rdata, rdata_valid, rdata_owner registered, tagged read return
//   busy                            command issued or read in flight
// ---------------------------------------------------------------------------
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic              alu_we,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_wdata,
  output logic              alu_gnt,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              mem_cs_n,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [1:0]        rdata_owner,
  output logic              busy
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_MAX_C = HOLD_CNT_W'(MAX_HOLD);

  // Arbitration state
  owner_e                owner_q;
  owner_e                rr_ptr_q;
  logic [HOLD_CNT_W-1:0] hold_cnt_q;

  // Read-tag pipeline: p0 travels with the SRAM command, p1 with mem_rdata.
  logic   rd_vld_p0;
  owner_e rd_own_p0;
  logic   rd_vld_p1;
  owner_e rd_own_p1;

  logic [2:0] req_vec;
  logic [2:0] own_oh;
  logic       owner_req;
  logic       others_pending;
  logic       keep_owner;
  logic [2:0] pick_gnt;
  owner_e     pick_owner;
  logic [2:0] gnt_vec;
  owner_e     gnt_owner;
  logic       gnt_any;
  logic       gnt_is_read;

  logic [HOLD_CNT_W-1:0] hold_cnt_d;
  logic                  cmd_web_d;
  logic [ADDR_W-1:0]     cmd_addr_d;
  logic [DATA_W-1:0]     cmd_wdata_d;

  assign req_vec        = {rd_req, ld_req, alu_req};
  assign own_oh         = owner_onehot(owner_q);
  assign owner_req      = (req_vec & own_oh) != 3'b000;
  assign others_pending = (req_vec & ~own_oh) != 3'b000;
  // The owner is only displaced once it has used its burst and someone waits.
  assign keep_owner     = owner_req && ((hold_cnt_q < HOLD_MAX_C) || !others_pending);

  rr_pick3 u_pick (
    .req   (req_vec),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .owner (pick_owner)
  );

  assign gnt_vec     = keep_owner ? own_oh  : pick_gnt;
  assign gnt_owner   = keep_owner ? owner_q : pick_owner;
  assign gnt_any     = gnt_vec != 3'b000;
  assign alu_gnt     = gnt_vec[0];
  assign ld_gnt      = gnt_vec[1];
  assign rd_gnt      = gnt_vec[2];
  assign gnt_is_read = (gnt_vec[0] && !alu_we) || gnt_vec[2];

  // Counter restarts at 1 on a change of owner and when a lone owner
  // runs past the limit, so it never exceeds MAX_HOLD.
  always_comb begin
    hold_cnt_d = '0;
    if (gnt_any) begin
      if ((gnt_owner == owner_q) && (hold_cnt_q != HOLD_MAX_C)) begin
        hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
      end else begin
        hold_cnt_d = HOLD_CNT_W'(1);
      end
    end
  end

  // Address/data hold their previous values when nothing is granted.
  always_comb begin
    cmd_web_d   = 1'b1;
    cmd_addr_d  = mem_addr;
    cmd_wdata_d = mem_wdata;
    if (gnt_vec[0]) begin
      cmd_web_d   = !alu_we;
      cmd_addr_d  = alu_addr;
      cmd_wdata_d = alu_wdata;
    end else if (gnt_vec[1]) begin
      cmd_web_d   = 1'b0;
      cmd_addr_d  = ld_addr;
      cmd_wdata_d = ld_wdata;
    end else if (gnt_vec[2]) begin
      cmd_addr_d  = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_NONE;
      rr_ptr_q   <= OWN_ALU;
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      if (gnt_any) begin
        owner_q  <= gnt_owner;
        rr_ptr_q <= next_rr(gnt_owner);
      end else begin
        owner_q  <= OWN_NONE;
      end
    end
  end

  // ---- stage p0: SRAM command (grant + 1) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cs_n  <= 1'b1;
      mem_web   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_vld_p0 <= 1'b0;
      rd_own_p0 <= OWN_NONE;
    end else begin
      mem_cs_n  <= !gnt_any;
      mem_web   <= cmd_web_d;
      mem_addr  <= cmd_addr_d;
      mem_wdata <= cmd_wdata_d;
      rd_vld_p0 <= gnt_is_read;
      rd_own_p0 <= gnt_owner;
    end
  end

  // ---- stage p1: SRAM drives mem_rdata (grant + 2) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_p1 <= 1'b0;
      rd_own_p1 <= OWN_NONE;
    end else begin
      rd_vld_p1 <= rd_vld_p0;
      rd_own_p1 <= rd_own_p0;
    end
  end

  // ---- stage p2: registered, tagged read return (grant + 3) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_owner <= OWN_NONE;
    end else begin
      rdata_valid <= rd_vld_p1;
      rdata_owner <= rd_vld_p1 ? rd_own_p1 : OWN_NONE;
      if (rd_vld_p1) begin
        rdata <= mem_rdata;
      end
    end
  end

  assign busy = !mem_cs_n || rd_vld_p0 || rd_vld_p1;

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_req, alu_we, alu_gnt;
  logic [7:0]  alu_addr;
  logic [31:0] alu_wdata;
  logic        ld_req, ld_gnt;
  logic [7:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        rd_req, rd_gnt;
  logic [7:0]  rd_addr;
  logic        mem_cs_n, mem_web;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic [1:0]  rdata_owner;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  sram_access_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_we(alu_we), .alu_addr(alu_addr), .alu_wdata(alu_wdata), .alu_gnt(alu_gnt),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .mem_cs_n(mem_cs_n), .mem_web(mem_web), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_owner(rdata_owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: one-cycle read latency, two preset words.
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (!rst) begin
      sram[8'h05] <= 32'h12345678;
      sram[8'h20] <= 32'hCAFEF00D;
      mem_rdata   <= 32'h0;
    end else if (!mem_cs_n) begin
      if (!mem_web) sram[mem_addr] <= mem_wdata;
      else          mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    alu_req = 0; alu_we = 0; alu_addr = 0; alu_wdata = 0;
    ld_req = 0; ld_addr = 0; ld_wdata = 0;
    rd_req = 0; rd_addr = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs_n"}, mem_cs_n, 1);
    chk({tag, "_web"}, mem_web, 1);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rvalid"}, rdata_valid, 0);
    chk({tag, "_rowner"}, rdata_owner, 3);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gnt"}, {rd_gnt, ld_gnt, alu_gnt}, 3'b000);
  endtask

  typedef struct {
    logic        alu_req, alu_we;
    logic [7:0]  alu_addr;
    logic [31:0] alu_wdata;
    logic        ld_req;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic [2:0]  e_gnt;
    logic        e_cs_n, e_web;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_rv;
    logic [1:0]  e_ro;
    logic [31:0] e_rdata;
    logic        e_busy;
  } vec_t;

  vec_t tv [14];
  logic [2:0] g;

  initial begin
    // One row per cycle: inputs for the cycle, expected grant for those
    // inputs, expected registered outputs in that cycle.
    //          alu: req we addr  wdata          ld: req addr  wdata          rd: req addr | gnt    cs  web addr  wdata          rv ro  rdata          busy
    tv[0]  = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b000,1'b1,1'b1,8'h00,32'h0,        1'b0,2'd3,32'h0,        1'b0};
    tv[1]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,8'h10,32'hDEADBEEF, 1'b0,8'h00, 3'b010,1'b1,1'b1,8'h00,32'h0,        1'b0,2'd3,32'h0,        1'b0};
    tv[2]  = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b1,8'h05, 3'b100,1'b0,1'b0,8'h10,32'hDEADBEEF, 1'b0,2'd3,32'h0,        1'b1};
    tv[3]  = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b000,1'b0,1'b1,8'h05,32'hDEADBEEF, 1'b0,2'd3,32'h0,        1'b1};
    tv[4]  = '{1'b1,1'b0,8'h10,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b001,1'b1,1'b1,8'h05,32'hDEADBEEF, 1'b0,2'd3,32'h0,        1'b1};
    tv[5]  = '{1'b1,1'b0,8'h20,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b001,1'b0,1'b1,8'h10,32'h0,        1'b1,2'd2,32'h12345678, 1'b1};
    tv[6]  = '{1'b1,1'b1,8'h20,32'h11112222, 1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b001,1'b0,1'b1,8'h20,32'h0,        1'b0,2'd3,32'h12345678, 1'b1};
    tv[7]  = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b000,1'b0,1'b0,8'h20,32'h11112222, 1'b1,2'd0,32'hDEADBEEF, 1'b1};
    tv[8]  = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b000,1'b1,1'b1,8'h20,32'h11112222, 1'b1,2'd0,32'hCAFEF00D, 1'b0};
    tv[9]  = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b1,8'h20, 3'b100,1'b1,1'b1,8'h20,32'h11112222, 1'b0,2'd3,32'hCAFEF00D, 1'b0};
    tv[10] = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b000,1'b0,1'b1,8'h20,32'h11112222, 1'b0,2'd3,32'hCAFEF00D, 1'b1};
    tv[11] = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b000,1'b1,1'b1,8'h20,32'h11112222, 1'b0,2'd3,32'hCAFEF00D, 1'b1};
    tv[12] = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b000,1'b1,1'b1,8'h20,32'h11112222, 1'b1,2'd2,32'h11112222, 1'b0};
    tv[13] = '{1'b0,1'b0,8'h00,32'h0,        1'b0,8'h00,32'h0,        1'b0,8'h00, 3'b000,1'b1,1'b1,8'h20,32'h11112222, 1'b0,2'd3,32'h11112222, 1'b0};

    set_idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Table: loader write, readback latency, ALU reads/writes, pipelined reads.
    for (int i = 0; i < 14; i++) begin
      alu_req = tv[i].alu_req; alu_we = tv[i].alu_we; alu_addr = tv[i].alu_addr; alu_wdata = tv[i].alu_wdata;
      ld_req = tv[i].ld_req; ld_addr = tv[i].ld_addr; ld_wdata = tv[i].ld_wdata;
      rd_req = tv[i].rd_req; rd_addr = tv[i].rd_addr;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), {rd_gnt, ld_gnt, alu_gnt}, tv[i].e_gnt);
      chk($sformatf("vec%0d_cs_n", i), mem_cs_n, tv[i].e_cs_n);
      chk($sformatf("vec%0d_web", i), mem_web, tv[i].e_web);
      chk($sformatf("vec%0d_addr", i), mem_addr, tv[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, tv[i].e_wdata);
      chk($sformatf("vec%0d_rvalid", i), rdata_valid, tv[i].e_rv);
      chk($sformatf("vec%0d_rowner", i), rdata_owner, tv[i].e_ro);
      chk($sformatf("vec%0d_rdata", i), rdata, tv[i].e_rdata);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].e_busy);
      @(posedge clk); #1;
    end

    // Burst bound: ALU requests for 10 cycles, RD waits from cycle 0.
    set_idle();
    alu_req = 1; alu_we = 1; rd_req = 1; rd_addr = 8'h07;
    for (int c = 0; c < 10; c++) begin
      alu_addr = 8'h40 + 8'(c); alu_wdata = 32'(c);
      @(negedge clk);
      g = {rd_gnt, ld_gnt, alu_gnt};
      chk($sformatf("burst_gnt%0d", c), g, (c == 4) ? 3'b100 : 3'b001);
      if (c == 5) begin
        chk("burst_rd_addr", mem_addr, 8'h07);
        chk("burst_rd_web", mem_web, 1);
      end
      @(posedge clk); #1;
      if (g[2]) rd_req = 0;
    end
    alu_req = 0;
    @(negedge clk);
    chk("burst_end_gnt", {rd_gnt, ld_gnt, alu_gnt}, 3'b000);
    @(posedge clk); #1;

    // Lone owner past the limit: loader alone for 9 cycles.
    set_idle();
    for (int c = 0; c < 12; c++) begin
      ld_req = (c >= 1 && c <= 9); ld_addr = 8'(c); ld_wdata = 32'(c);
      @(negedge clk);
      chk($sformatf("lone_ld_gnt%0d", c), ld_gnt, (c >= 1 && c <= 9));
      chk($sformatf("lone_other_gnt%0d", c), {rd_gnt, alu_gnt}, 2'b00);
      chk($sformatf("lone_cs_n%0d", c), mem_cs_n, !(c >= 2 && c <= 10));
      @(posedge clk); #1;
    end

    // Reset mid-read: ALU read granted, reset in the following cycle.
    set_idle();
    alu_req = 1; alu_we = 0; alu_addr = 8'h05;
    @(negedge clk);
    chk("rst_mid_gnt", {rd_gnt, ld_gnt, alu_gnt}, 3'b001);
    @(posedge clk); #1;
    set_idle();
    #2 rst = 1'b0;
    #1 chk_reset("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_rvalid%0d", c), rdata_valid, 0);
    end
    @(posedge clk); #1;

    // Three-way contention from idle; pointer must be back at ALU.
    alu_req = 1; alu_we = 0; alu_addr = 8'h01;
    ld_req = 1; ld_addr = 8'h02; ld_wdata = 32'hA5A5A5A5;
    rd_req = 1; rd_addr = 8'h03;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      g = {rd_gnt, ld_gnt, alu_gnt};
      chk($sformatf("contend_gnt%0d", c), g, (c == 3) ? 3'b000 : (3'b001 << c));
      chk($sformatf("contend_onehot%0d", c), $onehot0(g), 1);
      if (c >= 1) begin
        chk($sformatf("contend_cs_n%0d", c), mem_cs_n, 0);
        chk($sformatf("contend_addr%0d", c), mem_addr, 8'(c));
        chk($sformatf("contend_web%0d", c), mem_web, (c == 2) ? 1'b0 : 1'b1);
      end
      @(posedge clk); #1;
      if (g[0]) alu_req = 0;
      if (g[1]) ld_req = 0;
      if (g[2]) rd_req = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
